mem_arbiter_demux: RTL
======================

Name: mem_arbiter_demux

Overview:
- Shares the single physical-memory port between the I-cache and the D-cache.
- Grants one client at a time and forwards that client's request to pmem.
- Routes pmem_rdata and pmem_resp back to the granted client only, acting as a demultiplexer.
- Sits between the two caches and the cacheline adaptor/physical memory.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cacheline width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_read  in  1  I-cache line read request; held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line write-back request; held until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  read request to memory
- pmem_write  out  1  write request to memory
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion

Behaviour:
- Reset (async, immediate): state IDLE; all pmem_* outputs 0; i_resp, d_resp 0; i_rdata, d_rdata 0; last_grant = I.
- FSM states:
  - IDLE: no request is driven.
  - BUSY_I, BUSY_D: the granted request is driven on pmem.
  - DONE_I, DONE_D: the client resp pulse is asserted.
- IDLE arbitration:
  - d_req = d_read | d_write.
  - If d_req and i_read are both high, grant the client opposite to last_grant (round-robin).
  - If only one requests, grant it. If none, stay in IDLE.
- Grant capture: on the IDLE->BUSY_x edge, register the client's address, plus d_wdata and op for D.
  - pmem outputs are driven only from these registers, never combinationally from client inputs.
  - d_write and d_read both high is illegal; write wins.
- BUSY_x:
  - Assert pmem_read (or pmem_write for a D write) continuously until pmem_resp.
  - On pmem_resp: capture pmem_rdata into x_rdata (reads only; on writes, d_rdata holds), deassert the pmem request next cycle, go to DONE_x, set last_grant = x.
- DONE_x:
  - x_resp = 1 for exactly this cycle; pmem outputs 0; next state IDLE.
  - x_rdata holds its value until the next completed read for that client.
- Stale-request guard: in the IDLE cycle immediately after DONE_x, client x's request is ignored. This is because the client drops its request only after seeing resp. The other client may still be granted in that cycle.
- Latency:
  - Request seen in IDLE at cycle 0.
  - pmem request asserted at cycle 1.
  - pmem_resp at cycle k ≥ 1 gives x_resp at cycle k+1.
  - Back in IDLE at k+2.
  - Minimum back-to-back turnaround is 3 cycles plus memory latency.
- pmem_resp outside BUSY_x is ignored.
- A client dropping its request mid-BUSY does not abort: the transaction completes and resp still pulses.
- The non-granted client sees resp = 0 and rdata unchanged throughout.
- Reset asserted mid-transaction returns the FSM to IDLE with no resp pulse. The pmem side must tolerate the abandoned request.

Decomposition:
- Package mem_arb_types:
  - enum arb_state_t {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D}.
  - enum client_t {CLIENT_I, CLIENT_D}.
  - LINE_W and ADDR_W defaults.
- Sub-module mem_arb_ctrl: the FSM, round-robin bit, and stale-request guard. Outputs grant/load/resp controls.
- The top level holds the capture registers and the output demultiplexing.

Test Plan:
- I only: i_read=1, i_address=0x0000_1000; memory responds 4 cycles later with line 0xAA..AA -> pmem_read high cycles 1–4, pmem_address=0x1000; i_resp pulses 1 cycle with i_rdata=0xAA..AA; d_resp stays 0.
- D write: d_write=1, d_address=0x8000_0040, d_wdata=0x55..55 -> pmem_write=1 with that address/data until pmem_resp; d_resp pulses once; d_rdata unchanged.
- Simultaneous I and D from reset (last_grant=I) -> D served first, then I granted immediately after the guard cycle; exactly one resp per client, in order D then I.
- Held request after resp: D holds d_read one cycle past d_resp, no I request -> no second pmem transaction is started.
- Reset mid-BUSY_I: assert rst with pmem_read high -> pmem_read drops in the same cycle (async); no i_resp; after release, a new i_read is served normally.
- Spurious pmem_resp in IDLE -> no resp pulse; rdata outputs unchanged.

Source files
------------

// File: rtl/mem_arbiter_demux_pkg.sv
// Shared types and default widths for the I/D-cache memory arbiter.
package mem_arb_types;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } arb_state_t;

    typedef enum logic {
        CLIENT_I,
        CLIENT_D
    } client_t;

endpackage

// File: rtl/mem_arbiter_demux_ctrl.sv
// Arbiter control: grant FSM, round-robin bit and stale-request guard.
// Emits capture strobes for the datapath and the per-client resp pulses.
module mem_arb_ctrl
    import mem_arb_types::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_read,
    input  logic d_req,
    input  logic pmem_resp,
    output logic busy_i,
    output logic busy_d,
    output logic load_i,
    output logic load_d,
    output logic cap_i,
    output logic cap_d,
    output logic resp_i,
    output logic resp_d
);

    arb_state_t state_q, state_d;
    client_t    last_q, last_d;
    logic       guard_i_q, guard_i_d;
    logic       guard_d_q, guard_d_d;
    logic       i_ok, d_ok;

    // State, round-robin and guard registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= CLIENT_I;
            guard_i_q <= 1'b0;
            guard_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            guard_i_q <= guard_i_d;
            guard_d_q <= guard_d_d;
        end
    end

    // Next-state, arbitration and control strobes
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        load_i    = 1'b0;
        load_d    = 1'b0;
        cap_i     = 1'b0;
        cap_d     = 1'b0;
        // A client still holds its request the cycle after its resp; mask it once.
        guard_i_d = (state_q == DONE_I);
        guard_d_d = (state_q == DONE_D);
        i_ok      = i_read & ~guard_i_q;
        d_ok      = d_req & ~guard_d_q;
        case (state_q)
            IDLE: begin
                if (i_ok && d_ok) begin
                    if (last_q == CLIENT_I) begin
                        state_d = BUSY_D;
                        load_d  = 1'b1;
                    end else begin
                        state_d = BUSY_I;
                        load_i  = 1'b1;
                    end
                end else if (d_ok) begin
                    state_d = BUSY_D;
                    load_d  = 1'b1;
                end else if (i_ok) begin
                    state_d = BUSY_I;
                    load_i  = 1'b1;
                end
            end
            BUSY_I: begin
                if (pmem_resp) begin
                    cap_i   = 1'b1;
                    last_d  = CLIENT_I;
                    state_d = DONE_I;
                end
            end
            BUSY_D: begin
                if (pmem_resp) begin
                    cap_d   = 1'b1;
                    last_d  = CLIENT_D;
                    state_d = DONE_D;
                end
            end
            DONE_I:  state_d = IDLE;
            DONE_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_i = (state_q == BUSY_I);
    assign busy_d = (state_q == BUSY_D);
    assign resp_i = (state_q == DONE_I);
    assign resp_d = (state_q == DONE_D);

endmodule

// File: rtl/mem_arbiter_demux.sv
// Shares one physical-memory port between I-cache and D-cache.
// Holds the granted request in registers and demuxes read data back.
module mem_arbiter_demux
    import mem_arb_types::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    logic busy_i, busy_d, load_i, load_d, cap_i, cap_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    mem_arb_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .d_req     (d_read | d_write),
        .pmem_resp (pmem_resp),
        .busy_i    (busy_i),
        .busy_d    (busy_d),
        .load_i    (load_i),
        .load_d    (load_d),
        .cap_i     (cap_i),
        .cap_d     (cap_d),
        .resp_i    (i_resp),
        .resp_d    (d_resp)
    );

    // Request capture and returned-line registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Load on grant; capture read data only for the owner and only on reads
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (load_i) begin
            addr_d = i_address;
            wr_d   = 1'b0;
        end
        if (load_d) begin
            addr_d  = d_address;
            wdata_d = d_wdata;
            wr_d    = d_write;   // write wins if both are raised
        end
        if (cap_i) i_rdata_d = pmem_rdata;
        if (cap_d && !wr_q) d_rdata_d = pmem_rdata;
    end

    assign pmem_read    = (busy_i | busy_d) & ~wr_q;
    assign pmem_write   = busy_d & wr_q;
    assign pmem_address = (busy_i | busy_d) ? addr_q : '0;
    assign pmem_wdata   = pmem_write ? wdata_q : '0;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

endmodule
